// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the CPU control path.
//   - Opcode constants (4-bit instruction codes)
//   - ALU and memory micro-op constants (3-bit each)
//   - FSM state enum used by control_seq and exposed on state_out
//   - is_ram_read(): opcodes whose operand is fetched from RAM
package cpu_pkg;

  localparam int OPC_BITS  = 4;
  localparam int ALU_BITS  = 3;
  localparam int MEM_BITS  = 3;
  localparam int WCNT_BITS = 4;

  // Opcodes. Code 0 is the explicit no-operation slot.
  localparam logic [OPC_BITS-1:0] OP_NOP  = 4'd0;
  localparam logic [OPC_BITS-1:0] OP_LDI  = 4'd1;
  localparam logic [OPC_BITS-1:0] OP_LDA  = 4'd2;
  localparam logic [OPC_BITS-1:0] OP_STOA = 4'd3;
  localparam logic [OPC_BITS-1:0] OP_STOB = 4'd4;
  localparam logic [OPC_BITS-1:0] OP_ADD  = 4'd5;
  localparam logic [OPC_BITS-1:0] OP_ADDI = 4'd6;
  localparam logic [OPC_BITS-1:0] OP_ADDC = 4'd7;
  localparam logic [OPC_BITS-1:0] OP_SUB  = 4'd8;
  localparam logic [OPC_BITS-1:0] OP_SUBI = 4'd9;
  localparam logic [OPC_BITS-1:0] OP_SUBC = 4'd10;
  localparam logic [OPC_BITS-1:0] OP_SJMP = 4'd11;
  localparam logic [OPC_BITS-1:0] OP_JMP  = 4'd12;
  localparam logic [OPC_BITS-1:0] OP_BNEZ = 4'd13;
  localparam logic [OPC_BITS-1:0] OP_BEZ  = 4'd14;
  localparam logic [OPC_BITS-1:0] OP_HALT = 4'd15;

  // ALU micro-ops.
  localparam logic [ALU_BITS-1:0] ALU_NOOP     = 3'd0;
  localparam logic [ALU_BITS-1:0] ALU_BUSTOACC = 3'd1;
  localparam logic [ALU_BITS-1:0] ALU_ACCTOBUS = 3'd2;
  localparam logic [ALU_BITS-1:0] ALU_ADD      = 3'd3;
  localparam logic [ALU_BITS-1:0] ALU_ADDC     = 3'd4;
  localparam logic [ALU_BITS-1:0] ALU_SUB      = 3'd5;
  localparam logic [ALU_BITS-1:0] ALU_SUBC     = 3'd6;

  // Memory micro-ops.
  localparam logic [MEM_BITS-1:0] MEM_NOOP     = 3'd0;
  localparam logic [MEM_BITS-1:0] MEM_LDINSTRC = 3'd1;
  localparam logic [MEM_BITS-1:0] MEM_RAMTOBUS = 3'd2;
  localparam logic [MEM_BITS-1:0] MEM_BUSTORAM = 3'd3;
  localparam logic [MEM_BITS-1:0] MEM_IVTOBUS  = 3'd4;
  localparam logic [MEM_BITS-1:0] MEM_SJMP     = 3'd5;
  localparam logic [MEM_BITS-1:0] MEM_JMP      = 3'd6;

  // Sequencer states; the encoding is visible on state_out.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_READ   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_EXEC   = 3'd3,
    ST_PAUSE  = 3'd4,
    ST_HALTED = 3'd5
  } state_t;

  // Opcodes that read their operand from RAM (these see the wait states).
  function automatic logic is_ram_read(input logic [OPC_BITS-1:0] opc);
    logic rr;
    case (opc)
      OP_LDA, OP_ADD, OP_ADDC, OP_SUB, OP_SUBC: rr = 1'b1;
      default:                                  rr = 1'b0;
    endcase
    return rr;
  endfunction

endpackage

// File: rtl/uop_decode.sv
// uop_decode: combinational opcode-to-micro-op decoder.
// Ports:
//   opcode     in  : current instruction code
//   zero_flag  in  : accumulator zero, resolves BEZ/BNEZ
//   ram_read   out : opcode fetches its operand from RAM
//   exec_alu   out : ALU micro-op for the EXEC cycle
//   exec_mem   out : memory micro-op for the EXEC cycle
//   exec_ce    out : PC count enable in EXEC (0 for taken jumps and HALT)
//   exec_halt  out : opcode is HALT
module uop_decode
  import cpu_pkg::*;
(
  input  logic [OPC_BITS-1:0] opcode,
  input  logic                zero_flag,
  output logic                ram_read,
  output logic [ALU_BITS-1:0] exec_alu,
  output logic [MEM_BITS-1:0] exec_mem,
  output logic                exec_ce,
  output logic                exec_halt
);

  // Decode opcode (and branch condition) into EXEC-cycle controls.
  always_comb begin
    ram_read  = is_ram_read(opcode);
    exec_alu  = ALU_NOOP;
    exec_mem  = MEM_NOOP;
    exec_ce   = 1'b1;
    exec_halt = 1'b0;
    case (opcode)
      OP_LDI:  begin exec_alu = ALU_BUSTOACC; exec_mem = MEM_IVTOBUS;  end
      OP_LDA:  begin exec_alu = ALU_BUSTOACC; exec_mem = MEM_RAMTOBUS; end
      OP_STOA: begin exec_alu = ALU_ACCTOBUS; exec_mem = MEM_BUSTORAM; end
      OP_STOB: begin exec_mem = MEM_BUSTORAM; end
      OP_ADD:  begin exec_alu = ALU_ADD;      exec_mem = MEM_RAMTOBUS; end
      OP_ADDI: begin exec_alu = ALU_ADD;      exec_mem = MEM_IVTOBUS;  end
      OP_ADDC: begin exec_alu = ALU_ADDC;     exec_mem = MEM_RAMTOBUS; end
      OP_SUB:  begin exec_alu = ALU_SUB;      exec_mem = MEM_RAMTOBUS; end
      OP_SUBI: begin exec_alu = ALU_SUB;      exec_mem = MEM_IVTOBUS;  end
      OP_SUBC: begin exec_alu = ALU_SUBC;     exec_mem = MEM_RAMTOBUS; end
      // Jumps load the PC instead of counting it.
      OP_SJMP: begin exec_mem = MEM_SJMP; exec_ce = 1'b0; end
      OP_JMP:  begin exec_alu = ALU_ACCTOBUS; exec_mem = MEM_JMP; exec_ce = 1'b0; end
      OP_BNEZ: begin
        if (!zero_flag) begin
          exec_alu = ALU_ACCTOBUS; exec_mem = MEM_JMP; exec_ce = 1'b0;
        end else begin
          exec_ce = 1'b1;
        end
      end
      OP_BEZ: begin
        if (zero_flag) begin
          exec_alu = ALU_ACCTOBUS; exec_mem = MEM_JMP; exec_ce = 1'b0;
        end else begin
          exec_ce = 1'b1;
        end
      end
      OP_HALT: begin exec_ce = 1'b0; exec_halt = 1'b1; end
      // NOP and any unassigned code behave as a plain no-operation.
      default: begin exec_alu = ALU_NOOP; exec_mem = MEM_NOOP; end
    endcase
  end

endmodule

// File: rtl/control_seq.sv
// control_seq: instruction sequencer FSM (FETCH/READ/WAIT/EXEC/PAUSE/HALTED).
// Parameters:
//   OPC_W, ALU_UOP_W, MEM_UOP_W : widths of opcode and micro-op ports
//   RAM_WAIT                    : extra READ cycles for RAM-read opcodes (0..15)
// Ports:
//   clk, reset (sync, active-high)
//   instruction_code in  : current opcode
//   zero_flag        in  : accumulator zero (used in EXEC)
//   mem_ready        in  : memory handshake, low stalls FETCH/READ/WAIT
//   step_mode        in  : single-instruction debug mode
//   step_req         in  : advance one instruction while paused
//   resume           in  : leave HALTED
//   ce               out : PC count enable
//   halt_pc          out : PC halted indicator
//   alu_instruction  out : ALU micro-op
//   mem_instruction  out : memory micro-op
//   state_out        out : current state encoding (debug)
module control_seq
  import cpu_pkg::*;
#(
  parameter int OPC_W     = 4,
  parameter int ALU_UOP_W = 3,
  parameter int MEM_UOP_W = 3,
  parameter int RAM_WAIT  = 0
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [OPC_W-1:0]     instruction_code,
  input  logic                 zero_flag,
  input  logic                 mem_ready,
  input  logic                 step_mode,
  input  logic                 step_req,
  input  logic                 resume,
  output logic                 ce,
  output logic                 halt_pc,
  output logic [ALU_UOP_W-1:0] alu_instruction,
  output logic [MEM_UOP_W-1:0] mem_instruction,
  output logic [2:0]           state_out
);

  // Counter runs RAM_WAIT-1 down to 0, giving RAM_WAIT cycles in WAIT.
  localparam bit HAS_WAIT = (RAM_WAIT > 32'sd0);
  localparam logic [WCNT_BITS-1:0] WAIT_LOAD =
    HAS_WAIT ? WCNT_BITS'(RAM_WAIT - 32'sd1) : 4'd0;

  state_t                state_r;
  state_t                state_next_s;
  logic [WCNT_BITS-1:0]  wait_cnt_r;
  logic [WCNT_BITS-1:0]  wait_cnt_next_s;

  logic [OPC_BITS-1:0]   opc_s;
  logic                  ram_read_s;
  logic [ALU_BITS-1:0]   exec_alu_s;
  logic [MEM_BITS-1:0]   exec_mem_s;
  logic                  exec_ce_s;
  logic                  exec_halt_s;
  logic [ALU_BITS-1:0]   alu_s;
  logic [MEM_BITS-1:0]   mem_s;

  assign opc_s = OPC_BITS'(instruction_code);

  uop_decode u_decode (
    .opcode    (opc_s),
    .zero_flag (zero_flag),
    .ram_read  (ram_read_s),
    .exec_alu  (exec_alu_s),
    .exec_mem  (exec_mem_s),
    .exec_ce   (exec_ce_s),
    .exec_halt (exec_halt_s)
  );

  // State and wait-counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_FETCH;
      wait_cnt_r <= 4'd0;
    end else begin
      state_r    <= state_next_s;
      wait_cnt_r <= wait_cnt_next_s;
    end
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_next_s    = state_r;
    wait_cnt_next_s = wait_cnt_r;
    case (state_r)
      ST_FETCH: begin
        if (mem_ready) state_next_s = ST_READ;
        else           state_next_s = ST_FETCH;
      end
      ST_READ: begin
        if (mem_ready) begin
          if (ram_read_s && HAS_WAIT) begin
            state_next_s    = ST_WAIT;
            wait_cnt_next_s = WAIT_LOAD;
          end else begin
            state_next_s = ST_EXEC;
          end
        end else begin
          state_next_s = ST_READ;
        end
      end
      ST_WAIT: begin
        // Count down unconditionally; only the final cycle needs mem_ready.
        if (wait_cnt_r == 4'd0) begin
          if (mem_ready) state_next_s = ST_EXEC;
          else           state_next_s = ST_WAIT;
        end else begin
          wait_cnt_next_s = wait_cnt_r - 4'd1;
        end
      end
      ST_EXEC: begin
        if (exec_halt_s)    state_next_s = ST_HALTED;
        else if (step_mode) state_next_s = ST_PAUSE;
        else                state_next_s = ST_FETCH;
      end
      ST_PAUSE: begin
        if (step_req || !step_mode) state_next_s = ST_FETCH;
        else                        state_next_s = ST_PAUSE;
      end
      ST_HALTED: begin
        if (resume) state_next_s = ST_FETCH;
        else        state_next_s = ST_HALTED;
      end
      default: begin
        state_next_s    = ST_FETCH;
        wait_cnt_next_s = 4'd0;
      end
    endcase
  end

  // Micro-op, ce and halt outputs from state, opcode and zero_flag.
  always_comb begin
    ce      = 1'b0;
    halt_pc = 1'b0;
    alu_s   = ALU_NOOP;
    mem_s   = MEM_NOOP;
    case (state_r)
      ST_FETCH: mem_s = MEM_LDINSTRC;
      ST_READ, ST_WAIT: begin
        if (ram_read_s) mem_s = MEM_RAMTOBUS;
        else            mem_s = MEM_NOOP;
      end
      ST_EXEC: begin
        alu_s   = exec_alu_s;
        mem_s   = exec_mem_s;
        ce      = exec_ce_s;
        halt_pc = exec_halt_s;
      end
      // The resume cycle counts the PC once so execution steps past HALT.
      ST_HALTED: begin
        halt_pc = 1'b1;
        ce      = resume;
      end
      default: begin
        ce = 1'b0;
      end
    endcase
  end

  assign alu_instruction = ALU_UOP_W'(alu_s);
  assign mem_instruction = MEM_UOP_W'(mem_s);
  assign state_out       = state_r;

endmodule

// File: tb/tb_control_seq.sv
module tb_control_seq;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       reset, zero_flag, mem_ready, step_mode, step_req, resume;
  logic [3:0] instruction_code;
  logic       ce0, h0, ce2, h2;
  logic [2:0] alu0, mem0, st0, alu2, mem2, st2;
  logic       sel;
  logic [10:0] q[$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  control_seq #(.OPC_W(4), .ALU_UOP_W(3), .MEM_UOP_W(3), .RAM_WAIT(0)) dut0 (
    .clk(clk), .reset(reset), .instruction_code(instruction_code),
    .zero_flag(zero_flag), .mem_ready(mem_ready), .step_mode(step_mode),
    .step_req(step_req), .resume(resume), .ce(ce0), .halt_pc(h0),
    .alu_instruction(alu0), .mem_instruction(mem0), .state_out(st0));

  control_seq #(.OPC_W(4), .ALU_UOP_W(3), .MEM_UOP_W(3), .RAM_WAIT(2)) dut2 (
    .clk(clk), .reset(reset), .instruction_code(instruction_code),
    .zero_flag(zero_flag), .mem_ready(mem_ready), .step_mode(step_mode),
    .step_req(step_req), .resume(resume), .ce(ce2), .halt_pc(h2),
    .alu_instruction(alu2), .mem_instruction(mem2), .state_out(st2));

  // {state, ce, halt_pc, alu, mem}
  function automatic logic [10:0] ex(input logic [2:0] st, input logic c, input logic h,
                                     input logic [2:0] a, input logic [2:0] m);
    return {st, c, h, a, m};
  endfunction

  function automatic logic [10:0] obs();
    if (sel) return {st2, ce2, h2, alu2, mem2};
    else     return {st0, ce0, h0, alu0, mem0};
  endfunction

  // Expected EXEC controls {ce, halt, alu, mem} from the opcode table.
  function automatic logic [7:0] exp_exec(input logic [3:0] op, input logic z);
    case (op)
      OP_LDI:  return {1'b1, 1'b0, ALU_BUSTOACC, MEM_IVTOBUS};
      OP_LDA:  return {1'b1, 1'b0, ALU_BUSTOACC, MEM_RAMTOBUS};
      OP_STOA: return {1'b1, 1'b0, ALU_ACCTOBUS, MEM_BUSTORAM};
      OP_STOB: return {1'b1, 1'b0, ALU_NOOP,     MEM_BUSTORAM};
      OP_ADD:  return {1'b1, 1'b0, ALU_ADD,      MEM_RAMTOBUS};
      OP_ADDI: return {1'b1, 1'b0, ALU_ADD,      MEM_IVTOBUS};
      OP_ADDC: return {1'b1, 1'b0, ALU_ADDC,     MEM_RAMTOBUS};
      OP_SUB:  return {1'b1, 1'b0, ALU_SUB,      MEM_RAMTOBUS};
      OP_SUBI: return {1'b1, 1'b0, ALU_SUB,      MEM_IVTOBUS};
      OP_SUBC: return {1'b1, 1'b0, ALU_SUBC,     MEM_RAMTOBUS};
      OP_SJMP: return {1'b0, 1'b0, ALU_NOOP,     MEM_SJMP};
      OP_JMP:  return {1'b0, 1'b0, ALU_ACCTOBUS, MEM_JMP};
      OP_BNEZ: return z ? {1'b1, 1'b0, ALU_NOOP, MEM_NOOP} : {1'b0, 1'b0, ALU_ACCTOBUS, MEM_JMP};
      OP_BEZ:  return z ? {1'b0, 1'b0, ALU_ACCTOBUS, MEM_JMP} : {1'b1, 1'b0, ALU_NOOP, MEM_NOOP};
      OP_HALT: return {1'b0, 1'b1, ALU_NOOP, MEM_NOOP};
      default: return {1'b1, 1'b0, ALU_NOOP, MEM_NOOP};
    endcase
  endfunction

  task automatic idle_inputs();
    reset = 1'b0; zero_flag = 1'b0; mem_ready = 1'b1; step_mode = 1'b0;
    step_req = 1'b0; resume = 1'b0; instruction_code = OP_NOP;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    q.delete();
  endtask

  task automatic test_reset();
    logic [10:0] e, o;
    idle_inputs();
    reset = 1'b1; resume = 1'b1; step_req = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      q.push_back(ex(ST_FETCH, 1'b0, 1'b0, ALU_NOOP, MEM_LDINSTRC));
      e = q.pop_front(); o = obs(); checks++;
      if (o !== e) begin failures++; $display("FAIL reset dut=%0d got=%b exp=%b", s, o, e); end
    end
    idle_inputs();
  endtask

  task automatic test_addi();
    logic [10:0] e, o;
    sel = 1'b0; do_reset();
    instruction_code = OP_ADDI;
    for (int k = 0; k < 2; k++) begin
      q.push_back(ex(ST_FETCH, 1'b0, 1'b0, ALU_NOOP, MEM_LDINSTRC));
      q.push_back(ex(ST_READ,  1'b0, 1'b0, ALU_NOOP, MEM_NOOP));
      q.push_back(ex(ST_EXEC,  1'b1, 1'b0, ALU_ADD,  MEM_IVTOBUS));
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); e = q.pop_front(); o = obs(); checks++;
      if (o !== e) begin failures++; $display("FAIL addi cyc=%0d got=%b exp=%b", i, o, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lda_wait();
    logic [10:0] e, o;
    sel = 1'b1; do_reset();
    instruction_code = OP_LDA;
    q.push_back(ex(ST_FETCH, 1'b0, 1'b0, ALU_NOOP, MEM_LDINSTRC));
    q.push_back(ex(ST_READ,  1'b0, 1'b0, ALU_NOOP, MEM_RAMTOBUS));
    q.push_back(ex(ST_WAIT,  1'b0, 1'b0, ALU_NOOP, MEM_RAMTOBUS));
    q.push_back(ex(ST_WAIT,  1'b0, 1'b0, ALU_NOOP, MEM_RAMTOBUS));
    q.push_back(ex(ST_EXEC,  1'b1, 1'b0, ALU_BUSTOACC, MEM_RAMTOBUS));
    q.push_back(ex(ST_FETCH, 1'b0, 1'b0, ALU_NOOP, MEM_LDINSTRC));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); e = q.pop_front(); o = obs(); checks++;
      if (o !== e) begin failures++; $display("FAIL lda_wait cyc=%0d got=%b exp=%b", i, o, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_stall();
    logic [10:0] e, o;
    logic [6:0]  mr_pat;
    sel = 1'b0; do_reset();
    instruction_code = OP_ADDI; mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) q.push_back(ex(ST_FETCH, 1'b0, 1'b0, ALU_NOOP, MEM_LDINSTRC));
    q.push_back(ex(ST_READ, 1'b0, 1'b0, ALU_NOOP, MEM_NOOP));
    for (int i = 0; i < 5; i++) begin
      if (i == 3) mem_ready = 1'b1;
      @(negedge clk); e = q.pop_front(); o = obs(); checks++;
      if (o !== e) begin failures++; $display("FAIL fetch_stall cyc=%0d got=%b exp=%b", i, o, e); end
      @(posedge clk); #1;
    end
    // READ and final-WAIT stalls on the RAM_WAIT=2 instance.
    sel = 1'b1; do_reset();
    instruction_code = OP_ADD;
    mr_pat = 7'b1101101;
    q.push_back(ex(ST_FETCH, 1'b0, 1'b0, ALU_NOOP, MEM_LDINSTRC));
    q.push_back(ex(ST_READ,  1'b0, 1'b0, ALU_NOOP, MEM_RAMTOBUS));
    q.push_back(ex(ST_READ,  1'b0, 1'b0, ALU_NOOP, MEM_RAMTOBUS));
    for (int k = 0; k < 3; k++) q.push_back(ex(ST_WAIT, 1'b0, 1'b0, ALU_NOOP, MEM_RAMTOBUS));
    q.push_back(ex(ST_EXEC, 1'b1, 1'b0, ALU_ADD, MEM_RAMTOBUS));
    for (int i = 0; i < 7; i++) begin
      mem_ready = mr_pat[i];
      @(negedge clk); e = q.pop_front(); o = obs(); checks++;
      if (o !== e) begin failures++; $display("FAIL read_wait_stall cyc=%0d got=%b exp=%b", i, o, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_decode_back_to_back();
    logic [10:0] e, o;
    logic [7:0]  x;
    sel = 1'b0; do_reset();
    for (int op = 0; op < 15; op++) begin
      for (int z = 0; z < 2; z++) begin
        instruction_code = 4'(op); zero_flag = z[0];
        x = exp_exec(instruction_code, zero_flag);
        q.push_back(ex(ST_FETCH, 1'b0, 1'b0, ALU_NOOP, MEM_LDINSTRC));
        q.push_back(ex(ST_READ, 1'b0, 1'b0, ALU_NOOP,
                       (op == 2 || op == 5 || op == 7 || op == 8 || op == 10) ? MEM_RAMTOBUS : MEM_NOOP));
        q.push_back(ex(ST_EXEC, x[7], x[6], x[5:3], x[2:0]));
        for (int i = 0; i < 3; i++) begin
          @(negedge clk); e = q.pop_front(); o = obs(); checks++;
          if (o !== e) begin
            failures++;
            $display("FAIL decode op=%0d z=%0d cyc=%0d got=%b exp=%b", op, z, i, o, e);
          end
          @(posedge clk); #1;
        end
      end
    end
  endtask

  task automatic test_halt();
    logic [10:0] e, o;
    sel = 1'b0; do_reset();
    instruction_code = OP_HALT;
    q.push_back(ex(ST_FETCH, 1'b0, 1'b0, ALU_NOOP, MEM_LDINSTRC));
    q.push_back(ex(ST_READ,  1'b0, 1'b0, ALU_NOOP, MEM_NOOP));
    q.push_back(ex(ST_EXEC,  1'b0, 1'b1, ALU_NOOP, MEM_NOOP));
    for (int k = 0; k < 10; k++) q.push_back(ex(ST_HALTED, 1'b0, 1'b1, ALU_NOOP, MEM_NOOP));
    q.push_back(ex(ST_HALTED, 1'b1, 1'b1, ALU_NOOP, MEM_NOOP));
    q.push_back(ex(ST_FETCH,  1'b0, 1'b0, ALU_NOOP, MEM_LDINSTRC));
    for (int i = 0; i < 15; i++) begin
      if (i == 4)  instruction_code = OP_ADD;
      resume = (i == 13);
      @(negedge clk); e = q.pop_front(); o = obs(); checks++;
      if (o !== e) begin failures++; $display("FAIL halt cyc=%0d got=%b exp=%b", i, o, e); end
      @(posedge clk); #1;
    end
    resume = 1'b0;
  endtask

  task automatic test_step();
    logic [10:0] e, o;
    sel = 1'b0; do_reset();
    instruction_code = OP_SUB; step_mode = 1'b1;
    for (int k = 0; k < 2; k++) begin
      q.push_back(ex(ST_FETCH, 1'b0, 1'b0, ALU_NOOP, MEM_LDINSTRC));
      q.push_back(ex(ST_READ,  1'b0, 1'b0, ALU_NOOP, MEM_RAMTOBUS));
      q.push_back(ex(ST_EXEC,  1'b1, 1'b0, ALU_SUB,  MEM_RAMTOBUS));
      for (int p = 0; p < (k == 0 ? 3 : 2); p++)
        q.push_back(ex(ST_PAUSE, 1'b0, 1'b0, ALU_NOOP, MEM_NOOP));
    end
    q.push_back(ex(ST_FETCH, 1'b0, 1'b0, ALU_NOOP, MEM_LDINSTRC));
    for (int i = 0; i < 12; i++) begin
      step_req  = (i == 5);
      step_mode = (i < 10);
      @(negedge clk); e = q.pop_front(); o = obs(); checks++;
      if (o !== e) begin failures++; $display("FAIL step cyc=%0d got=%b exp=%b", i, o, e); end
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic test_reset_midway();
    logic [10:0] e, o;
    sel = 1'b1; do_reset();
    instruction_code = OP_LDA;
    q.push_back(ex(ST_FETCH, 1'b0, 1'b0, ALU_NOOP, MEM_LDINSTRC));
    q.push_back(ex(ST_READ,  1'b0, 1'b0, ALU_NOOP, MEM_RAMTOBUS));
    q.push_back(ex(ST_WAIT,  1'b0, 1'b0, ALU_NOOP, MEM_RAMTOBUS));
    q.push_back(ex(ST_FETCH, 1'b0, 1'b0, ALU_NOOP, MEM_LDINSTRC));
    q.push_back(ex(ST_READ,  1'b0, 1'b0, ALU_NOOP, MEM_RAMTOBUS));
    q.push_back(ex(ST_WAIT,  1'b0, 1'b0, ALU_NOOP, MEM_RAMTOBUS));
    q.push_back(ex(ST_WAIT,  1'b0, 1'b0, ALU_NOOP, MEM_RAMTOBUS));
    q.push_back(ex(ST_EXEC,  1'b1, 1'b0, ALU_BUSTOACC, MEM_RAMTOBUS));
    for (int i = 0; i < 8; i++) begin
      reset = (i == 2);
      @(negedge clk); e = q.pop_front(); o = obs(); checks++;
      if (o !== e) begin failures++; $display("FAIL reset_in_wait cyc=%0d got=%b exp=%b", i, o, e); end
      @(posedge clk); #1;
    end
    // Reset out of HALTED.
    sel = 1'b0; do_reset();
    instruction_code = OP_HALT;
    q.push_back(ex(ST_FETCH,  1'b0, 1'b0, ALU_NOOP, MEM_LDINSTRC));
    q.push_back(ex(ST_READ,   1'b0, 1'b0, ALU_NOOP, MEM_NOOP));
    q.push_back(ex(ST_EXEC,   1'b0, 1'b1, ALU_NOOP, MEM_NOOP));
    q.push_back(ex(ST_HALTED, 1'b0, 1'b1, ALU_NOOP, MEM_NOOP));
    q.push_back(ex(ST_HALTED, 1'b0, 1'b1, ALU_NOOP, MEM_NOOP));
    q.push_back(ex(ST_FETCH,  1'b0, 1'b0, ALU_NOOP, MEM_LDINSTRC));
    for (int i = 0; i < 6; i++) begin
      reset = (i == 4);
      @(negedge clk); e = q.pop_front(); o = obs(); checks++;
      if (o !== e) begin failures++; $display("FAIL reset_in_halted cyc=%0d got=%b exp=%b", i, o, e); end
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  initial begin
    sel = 1'b0;
    idle_inputs();
    #1;
    test_reset();
    test_addi();
    test_lda_wait();
    test_mem_stall();
    test_decode_back_to_back();
    test_halt();
    test_step();
    test_reset_midway();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_seq.md
CONTROL_SEQ -- requirements
Module: control_seq

Interface
REQ-001 SHALL have parameter OPC_W, default 4, meaning instruction_code width.
REQ-002 SHALL have parameter ALU_UOP_W, default 3, meaning alu_instruction width.
REQ-003 SHALL have parameter MEM_UOP_W, default 3, meaning mem_instruction width.
REQ-004 SHALL have parameter RAM_WAIT, default 0, meaning extra READ cycles inserted for RAM-read opcodes (0..15).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port instruction_code, input, OPC_W bits: current opcode.
REQ-008 SHALL have port zero_flag, input, 1 bit: accumulator zero, sampled combinationally in EXEC.
REQ-009 SHALL have port mem_ready, input, 1 bit: memory handshake; low stalls FETCH/READ.
REQ-010 SHALL have port step_mode, input, 1 bit: single-instruction debug mode.
REQ-011 SHALL have port step_req, input, 1 bit: advance one instruction while paused.
REQ-012 SHALL have port resume, input, 1 bit: leave HALTED.
REQ-013 SHALL have port ce, output, 1 bit: PC count enable.
REQ-014 SHALL have port halt_pc, output, 1 bit: PC halted indicator.
REQ-015 SHALL have port alu_instruction, output, ALU_UOP_W bits: ALU micro-op.
REQ-016 SHALL have port mem_instruction, output, MEM_UOP_W bits: memory micro-op.
REQ-017 SHALL have port state_out, output, 3 bits: current FSM state encoding (debug).

Function
REQ-018 FSM states SHALL be FETCH, READ, WAIT, EXEC, PAUSE, HALTED.
REQ-019 FETCH: mem=LDINSTRC, alu=NOOP; to READ when mem_ready=1, else hold.
REQ-020 READ: mem=RAMTOBUS for LDA/ADD/ADDC/SUB/SUBC, else NOOP; when mem_ready=1, to WAIT if RAM-read opcode and RAM_WAIT>0, else EXEC; mem_ready=0 holds.
REQ-021 WAIT: same micro-ops as READ; 4-bit counter loads RAM_WAIT-1 on entry and decrements; to EXEC when counter=0 and mem_ready=1.
REQ-022 EXEC micro-ops SHALL be: LDI/LDA alu=BUSTOACC; STOA alu=ACCTOBUS, mem=BUSTORAM; STOB mem=BUSTORAM; ADD/ADDI ADD; ADDC ADDC; SUB/SUBI SUB; SUBC SUBC; LDI/ADDI/SUBI mem=IVTOBUS; LDA/ADD/ADDC/SUB/SUBC mem=RAMTOBUS; SJMP mem=SJMP; JMP alu=ACCTOBUS, mem=JMP; BNEZ/BEZ as JMP when taken, NOOP otherwise.
REQ-023 EXEC ce SHALL be 1 except for taken jumps/branches (0) and HALT (0); EXEC is always exactly one cycle.
REQ-024 EXEC exit: HALT->HALTED; else step_mode=1 -> PAUSE; else FETCH.
REQ-025 PAUSE: all micro-ops NOOP, ce=0; to FETCH on step_req=1; step_mode deassert also goes to FETCH.
REQ-026 HALTED: halt_pc=1, ce=0, micro-ops NOOP; on resume=1, ce=1 for that cycle (steps past HALT) and go to FETCH.
REQ-027 halt_pc SHALL be 1 only in HALTED and in EXEC with HALT opcode; 0 elsewhere.
REQ-028 Undefined opcodes SHALL execute as NOP (all NOOP, ce=1 in EXEC).
REQ-029 Outputs other than state_out SHALL be combinational from state, opcode, zero_flag.

Reset
REQ-030 reset=1 SHALL force state FETCH and wait counter 0 at next edge, from any state including mid-WAIT or HALTED, overriding resume/step_req.
REQ-031 While in reset-state: ce=0, halt_pc=0, alu=NOOP, mem=LDINSTRC, state_out=FETCH encoding.

Structure
REQ-032 Opcode constants, ALU/MEM micro-op constants and the state enum typedef SHALL live in shared package cpu_pkg.
REQ-033 Opcode-to-micro-op decode SHALL be sub-module uop_decode (combinational); control_seq holds FSM and wait counter.

Verification
REQ-034 ADDI, RAM_WAIT=0, mem_ready=1 -> states FETCH,READ,EXEC; EXEC alu=ADD, mem=IVTOBUS, ce=1; 3 cycles/instr.
REQ-035 LDA, RAM_WAIT=2 -> FETCH,READ,WAIT,WAIT,EXEC; mem=RAMTOBUS in READ/WAIT/EXEC; 5 cycles.
REQ-036 mem_ready=0 for 3 cycles in FETCH -> FETCH held 4 cycles, ce=0 throughout.
REQ-037 BEZ with zero_flag=1 -> EXEC alu=ACCTOBUS, mem=JMP, ce=0; zero_flag=0 -> NOOP, ce=1.
REQ-038 HALT -> HALTED, halt_pc=1 held 10 cycles; resume pulse -> ce=1 one cycle, then FETCH.
REQ-039 step_mode=1, SUB -> PAUSE after EXEC; step_req pulse -> FETCH; reset asserted in WAIT -> FETCH next edge.
